mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//   Shares the single 8-bit program/data memory between N requesters: 0 = CPU, 1 = program loader,
//   2 = debug/host port. Serialises accesses, issues one command per grant to the memory and returns
//   read data to the winner. Sits between the requesters and the memory, beside the run controller.
// PARAMETERS
//   N        3   number of requesters (2..8)
//   AW       8   address width
//   DW       8   data width
//   MAX_WAIT 4   lost arbitrations before a waiting requester is promoted in fixed mode (1..15)
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   reset      in   1      asynchronous, active-high reset
//   prio_mode  in   1      0 = round-robin, 1 = fixed priority (lowest index wins) with starvation promotion
//   req        in   N      access request, one bit per requester; hold until gnt
//   we         in   N      1 = write, 0 = read; stable while req high
//   addr       in   N*AW   flattened addresses, requester i at [i*AW +: AW]
//   wdata      in   N*DW   flattened write data, requester i at [i*DW +: DW]
//   gnt        out  N      one-hot, 1-cycle pulse: request i accepted
//   rvalid     out  N      one-hot, 1-cycle pulse: rdata valid for requester i
//   rdata      out  DW     read data, valid only with rvalid
//   mem_en     out  1      memory command strobe
//   mem_we     out  1      memory write enable (qualified by mem_en)
//   mem_addr   out  AW     memory address
//   mem_wdata  out  DW     memory write data
//   mem_rdata  in   DW     memory read data, valid exactly 1 cycle after mem_en with mem_we=0
// BEHAVIOUR
//   Reset (async, any state): gnt, rvalid, mem_en, mem_we = 0; rdata, mem_addr, mem_wdata = 0; state ARB;
//     RR pointer = N-1 (requester 0 checked first); all wait counters = 0.
//   FSM: ARB -> ISSUE -> (read) RESP -> ARB; (write) ISSUE -> ARB.
//   ARB: if any req, pick winner w, capture we/addr/wdata of w, go ISSUE; else stay. Idle outputs all 0.
//   ISSUE (1 cycle): gnt[w]=1, mem_en=1, mem_we/addr/wdata from captured copy. Write -> ARB; read -> RESP.
//   RESP (1 cycle): rdata <= mem_rdata registered, rvalid[w]=1 in following cycle (ARB); next
//     arbitration runs in that same ARB cycle.
//   Latency: req sampled at cycle T -> gnt/mem_en at T+1 -> read rvalid at T+3. Throughput: write 1 per
//     2 cycles, read 1 per 3 cycles.
//   Round-robin: search from pointer+1 modulo N; pointer <= w on each grant.
//   Fixed: lowest index whose wait counter == MAX_WAIT wins; if none, lowest index with req wins.
//   Wait counter i: +1 (saturating at MAX_WAIT) on each ARB decision lost while req[i]=1; cleared on grant
//     to i or when req[i]=0. Counters maintained in both modes; pointer updated in both modes.
//   Withdrawal: deasserting req before capture is legal and ignored. Once captured, the access completes
//     even if req drops; requesters must not change we/addr/wdata until gnt.
//   prio_mode change takes effect at the next ARB decision; never aborts an access.
//   Single requester asserting continuously is granted every 2 (write) / 3 (read) cycles.
//   gnt, rvalid never have more than one bit set; mem_en never asserted outside ISSUE.
// TESTING
//   1. Reset during RESP (read to 0x10 in flight) -> all outputs 0 next cycle, no rvalid; after release
//      req0 read 0x10 completes normally with rvalid[0] at T+3.
//   2. RR, req=3'b111 held, all reads -> grant order 0,1,2,0,1,2, gnt every 3 cycles, rvalid matches.
//   3. Fixed, req0 writes continuously, req2 read 0x55 -> req2 granted after exactly 4 lost decisions,
//      then req0 resumes; mem_addr=0x55 at req2's ISSUE.
//   4. Write 0xA5 to 0x20 by req1 then read 0x20 by req2 (memory model) -> rdata=0xA5, rvalid=3'b100.
//   5. req1 pulsed for 1 cycle while ISSUE of req0 active -> req1 never granted, no counter residue.
//   6. prio_mode toggled mid-access -> current access completes unchanged; next decision uses new mode.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-side signals of the shared program/data memory arbiter.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface mem_bus_arbiter_if #(
   parameter int N  = 3,
   parameter int AW = 8,
   parameter int DW = 8
);
   logic            prio_mode;
   logic [N-1:0]    req;
   logic [N-1:0]    we;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wdata;
   logic [N-1:0]    gnt;
   logic [N-1:0]    rvalid;
   logic [DW-1:0]   rdata;
   logic            mem_en;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_rdata;

   modport slave (
      input  prio_mode, req, we, addr, wdata, mem_rdata,
      output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output prio_mode, req, we, addr, wdata, mem_rdata,
      input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Serialises CPU / loader / debug accesses onto the single memory port.
// Round-robin or fixed priority with starvation promotion; one command per grant.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_ARB   | pick a winner from req, capture its command; rvalid pulse here
//   S_ISSUE | gnt pulse and memory command strobe from the captured copy
//   S_RESP  | read only: register mem_rdata, raise rvalid in next S_ARB
module mem_bus_arbiter #(
   parameter int N        = 3,
   parameter int AW       = 8,
   parameter int DW       = 8,
   parameter int MAX_WAIT = 4
) (
   input  logic                clk,
   input  logic                reset,
   mem_bus_arbiter_if.slave    bus
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = 4;
   localparam logic [1:0]   S_ARB   = 2'd0;
   localparam logic [1:0]   S_ISSUE = 2'd1;
   localparam logic [1:0]   S_RESP  = 2'd2;
   localparam logic [N-1:0] ONE_N   = 1;
   localparam logic [IW:0]  ONE_SH  = 1;

   logic [1:0]    r_state;
   logic [IW-1:0] r_win;
   logic [IW-1:0] r_ptr;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_rdata;
   logic [N-1:0]  r_rvalid;
   logic [CW-1:0] r_wait [N];

   logic            w_any;
   logic            w_found;
   logic [IW-1:0]   w_win;
   logic [2*N-1:0]  w_req2;
   logic [2*N-1:0]  w_shifted;
   logic [N-1:0]    w_rot;
   logic            w_issue;

   assign w_any     = |bus.req;
   assign w_issue   = (r_state == S_ISSUE);
   // Rotate so that bit 0 is the requester just after the RR pointer.
   assign w_req2    = {bus.req, bus.req};
   assign w_shifted = w_req2 >> ({1'b0, r_ptr} + ONE_SH);
   assign w_rot     = w_shifted[N-1:0];

   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      if (bus.prio_mode) begin
         for (int i = 0; i < N; i++) begin
            if (!w_found && bus.req[i] && (r_wait[i] == CW'(MAX_WAIT))) begin
               w_found = 1'b1;
               w_win   = IW'(i);
            end
         end
         for (int i = 0; i < N; i++) begin
            if (!w_found && bus.req[i]) begin
               w_found = 1'b1;
               w_win   = IW'(i);
            end
         end
      end else begin
         for (int j = 0; j < N; j++) begin
            if (!w_found && w_rot[j]) begin
               w_found = 1'b1;
               w_win   = IW'((int'(r_ptr) + 1 + j) % N);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_ARB;
         r_win    <= '0;
         r_ptr    <= IW'(N - 1);
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_rvalid <= '0;
      end else begin
         r_rvalid <= '0;
         case (r_state)
            S_ARB: begin
               if (w_any) begin
                  r_win   <= w_win;
                  r_ptr   <= w_win;
                  r_we    <= bus.we[w_win];
                  r_addr  <= bus.addr[int'(w_win)*AW +: AW];
                  r_wdata <= bus.wdata[int'(w_win)*DW +: DW];
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: r_state <= r_we ? S_ARB : S_RESP;
            S_RESP: begin
               r_rdata  <= bus.mem_rdata;
               r_rvalid <= ONE_N << r_win;
               r_state  <= S_ARB;
            end
            default: r_state <= S_ARB;
         endcase
      end
   end

   // Counters only move on real arbitration decisions; a dropped request clears at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++) r_wait[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (!bus.req[i]) begin
               r_wait[i] <= '0;
            end else if (r_state == S_ARB) begin
               if (w_win == IW'(i)) r_wait[i] <= '0;
               else if (r_wait[i] != CW'(MAX_WAIT)) r_wait[i] <= r_wait[i] + CW'(1);
            end
         end
      end
   end

   assign bus.gnt       = w_issue ? (ONE_N << r_win) : '0;
   assign bus.mem_en    = w_issue;
   assign bus.mem_we    = w_issue & r_we;
   assign bus.mem_addr  = w_issue ? r_addr : '0;
   assign bus.mem_wdata = w_issue ? r_wdata : '0;
   assign bus.rvalid    = r_rvalid;
   assign bus.rdata     = r_rdata;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a 256-byte synchronous memory model.
// Unwritten memory locations read back as addr ^ 8'h3C.
module tb_mem_bus_arbiter;
   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   mem_bus_arbiter_if #(.N(3), .AW(8), .DW(8)) bus ();

   mem_bus_arbiter #(.N(3), .AW(8), .DW(8), .MAX_WAIT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] mem [256];
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
      bus.mem_rdata = 8'h00;
      forever begin
         @(posedge clk);
         if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
         else if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
      bus.req[i]          = 1'b1;
      bus.we[i]           = w;
      bus.addr[i*8 +: 8]  = a;
      bus.wdata[i*8 +: 8] = d;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      bus.prio_mode = 1'b0;
      bus.req       = '0;
      bus.we        = '0;
      bus.addr      = '0;
      bus.wdata     = '0;
      step();
      step();
      check("rst_gnt",       bus.gnt,       32'h0);
      check("rst_rvalid",    bus.rvalid,    32'h0);
      check("rst_mem_en",    bus.mem_en,    32'h0);
      check("rst_mem_we",    bus.mem_we,    32'h0);
      check("rst_mem_addr",  bus.mem_addr,  32'h0);
      check("rst_mem_wdata", bus.mem_wdata, 32'h0);
      check("rst_rdata",     bus.rdata,     32'h0);
      reset = 1'b0;

      // 1: reset while a read of 0x10 sits in RESP, then redo it cleanly
      set_req(0, 1'b0, 8'h10, 8'h00);
      step();
      check("t1_gnt",  bus.gnt,      32'h1);
      check("t1_addr", bus.mem_addr, 32'h10);
      bus.req = '0;
      step();
      reset = 1'b1;
      #1;
      check("t1_rst_gnt",    bus.gnt,      32'h0);
      check("t1_rst_mem_en", bus.mem_en,   32'h0);
      check("t1_rst_rvalid", bus.rvalid,   32'h0);
      check("t1_rst_addr",   bus.mem_addr, 32'h0);
      step();
      check("t1_rst_rvalid2", bus.rvalid, 32'h0);
      reset = 1'b0;
      set_req(0, 1'b0, 8'h10, 8'h00);
      step();
      check("t1_re_gnt", bus.gnt, 32'h1);
      bus.req = '0;
      step();
      check("t1_re_rvalid_early", bus.rvalid, 32'h0);
      step();
      check("t1_re_rvalid", bus.rvalid, 32'h1);
      check("t1_re_rdata",  bus.rdata,  32'h2C);

      // 2: round-robin, all three reading continuously
      do_reset();
      set_req(0, 1'b0, 8'h00, 8'h00);
      set_req(1, 1'b0, 8'h01, 8'h00);
      set_req(2, 1'b0, 8'h02, 8'h00);
      for (int n = 0; n < 6; n++) begin
         step();
         check($sformatf("t2_gnt_%0d", n),  bus.gnt,      32'(1 << (n % 3)));
         check($sformatf("t2_addr_%0d", n), bus.mem_addr, 32'(n % 3));
         step();
         check($sformatf("t2_gnt_resp_%0d", n), bus.gnt, 32'h0);
         step();
         check($sformatf("t2_rvalid_%0d", n), bus.rvalid, 32'(1 << (n % 3)));
         check($sformatf("t2_rdata_%0d", n),  bus.rdata,  32'((n % 3) ^ 8'h3C));
      end
      bus.req = '0;
      step();
      check("t2_idle_mem_en", bus.mem_en, 32'h0);

      // 3: fixed priority, req0 writes back-to-back, req2 promoted after 4 losses
      do_reset();
      bus.prio_mode = 1'b1;
      set_req(0, 1'b1, 8'h80, 8'h11);
      set_req(2, 1'b0, 8'h55, 8'h00);
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("t3_gnt0_%0d", k),   bus.gnt,    32'h1);
         check($sformatf("t3_we0_%0d", k),    bus.mem_we, 32'h1);
         step();
         check($sformatf("t3_gap_%0d", k),    bus.gnt,    32'h0);
      end
      step();
      check("t3_gnt2",   bus.gnt,      32'h4);
      check("t3_addr2",  bus.mem_addr, 32'h55);
      check("t3_we2",    bus.mem_we,   32'h0);
      bus.req[2] = 1'b0;
      step();
      step();
      check("t3_rvalid2", bus.rvalid, 32'h4);
      check("t3_rdata2",  bus.rdata,  32'h69);
      step();
      check("t3_resume0", bus.gnt, 32'h1);
      bus.req = '0;
      step();

      // 4: write 0xA5 to 0x20 by req1, read back by req2
      bus.prio_mode = 1'b0;
      set_req(1, 1'b1, 8'h20, 8'hA5);
      step();
      check("t4_gnt1",  bus.gnt,       32'h2);
      check("t4_we",    bus.mem_we,    32'h1);
      check("t4_addr",  bus.mem_addr,  32'h20);
      check("t4_wdata", bus.mem_wdata, 32'hA5);
      bus.req = '0;
      step();
      set_req(2, 1'b0, 8'h20, 8'h00);
      step();
      check("t4_gnt2", bus.gnt, 32'h4);
      bus.req = '0;
      step();
      step();
      check("t4_rvalid", bus.rvalid, 32'h4);
      check("t4_rdata",  bus.rdata,  32'hA5);

      // 5: req1 pulsed only during req0's ISSUE
      set_req(0, 1'b1, 8'h81, 8'h22);
      step();
      check("t5_gnt0", bus.gnt, 32'h1);
      bus.req = 3'b010;
      bus.addr[15:8] = 8'h33;
      step();
      bus.req = '0;
      check("t5_no_gnt_a", bus.gnt, 32'h0);
      step();
      check("t5_no_gnt_b", bus.gnt,    32'h0);
      check("t5_no_en",    bus.mem_en, 32'h0);
      step();
      check("t5_no_gnt_c", bus.gnt, 32'h0);

      // 6: prio_mode flipped mid-access
      do_reset();
      bus.prio_mode = 1'b0;
      set_req(0, 1'b0, 8'h40, 8'h00);
      step();
      check("t6_gnt0", bus.gnt, 32'h1);
      bus.req = '0;
      bus.prio_mode = 1'b1;
      #1;
      check("t6_addr_kept", bus.mem_addr, 32'h40);
      check("t6_we_kept",   bus.mem_we,   32'h0);
      step();
      set_req(0, 1'b0, 8'h41, 8'h00);
      set_req(1, 1'b0, 8'h42, 8'h00);
      step();
      check("t6_rvalid", bus.rvalid, 32'h1);
      check("t6_rdata",  bus.rdata,  32'h7C);
      step();
      check("t6_fixed_gnt",  bus.gnt,      32'h1);
      check("t6_fixed_addr", bus.mem_addr, 32'h41);
      bus.req[0] = 1'b0;
      bus.prio_mode = 1'b0;
      step();
      set_req(0, 1'b0, 8'h43, 8'h00);
      step();
      check("t6_rvalid_b", bus.rvalid, 32'h1);
      check("t6_rdata_b",  bus.rdata,  32'h7D);
      step();
      check("t6_rr_gnt",  bus.gnt,      32'h2);
      check("t6_rr_addr", bus.mem_addr, 32'h42);
      bus.req = '0;
      step();
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
